// File: rtl/piano_pkg.sv
// piano_pkg: shared constants and types for the polyphonic tone engine.
//   HALF_PERIOD : half-period (in 50 MHz clk cycles) of the chromatic notes
//                 C4 (index 0) up to D#5 (index 15).
//   HALF_MIN    : smallest half-period allowed after the octave shift.
//   sample_t    : signed audio sample at the default 16-bit width.
package piano_pkg;

  localparam int TAB_N = 16;
  localparam int TAB_W = 20;

  typedef logic [TAB_N-1:0][TAB_W-1:0] half_tab_t;

  // Leftmost entry is index 15 (D#5), rightmost is index 0 (C4).
  localparam half_tab_t HALF_PERIOD = {
    20'd40177, 20'd42566, 20'd45097, 20'd47778,
    20'd50619, 20'd53629, 20'd56818, 20'd60197,
    20'd63776, 20'd67568, 20'd71586, 20'd75843,
    20'd80353, 20'd85131, 20'd90193, 20'd95556
  };

  localparam int HALF_MIN = 1;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave oscillator channel.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   key_i           synchronised key level (1 = pressed)
//   decay_tick_i    shared envelope step strobe (VOLUME_ENVELOPE_EN only)
//   half_base_i     unshifted half-period for this key
//   octave_i        octave shift applied at every reload
//   contrib_o       signed contribution: +level in high phase, -level in low phase
// Optional feature macro: VOLUME_ENVELOPE_EN (release decay envelope).
module tone_channel
  import piano_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int AMP      = 4096,
  parameter int PERIOD_W = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       key_i,
`ifdef VOLUME_ENVELOPE_EN
  input  logic                       decay_tick_i,
`endif
  input  logic [PERIOD_W-1:0]        half_base_i,
  input  logic [1:0]                 octave_i,
  output logic signed [SAMPLE_W-1:0] contrib_o
);

  logic [PERIOD_W-1:0]        cnt_q, cnt_d, half_s;
  logic                       phase_q, phase_d;
  logic                       run_s;
  logic signed [SAMPLE_W-1:0] level_s;

  // Shifted half-period, never allowed to collapse to zero.
  always_comb begin
    half_s = half_base_i >> octave_i;
    if (half_s == '0) begin
      half_s = PERIOD_W'(HALF_MIN);
    end else begin
      half_s = half_s;
    end
  end

`ifdef VOLUME_ENVELOPE_EN
  logic [SAMPLE_W-2:0] level_q, level_d;

  // Envelope: jump to full amplitude on press, step down on each tick after release.
  always_comb begin
    level_d = level_q;
    if (key_i) begin
      level_d = (SAMPLE_W-1)'(AMP);
    end else if (decay_tick_i && (level_q != '0)) begin
      level_d = level_q - (SAMPLE_W-1)'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Envelope level register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign run_s   = key_i | (level_q != '0);
  assign level_s = $signed({1'b0, level_q});
`else
  assign run_s   = key_i;
  assign level_s = key_i ? SAMPLE_W'(AMP) : '0;
`endif

  // Oscillator next state; an idle channel parks at counter 0 / phase 0 so
  // the first active cycle toggles immediately (phase-aligned start).
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (run_s) begin
      if (cnt_q == '0) begin
        cnt_d   = half_s - PERIOD_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q - PERIOD_W'(1);
        phase_d = phase_q;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  // Oscillator state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign contrib_o = phase_q ? level_s : -level_s;

endmodule

// File: rtl/poly_tone_mixer.sv
// poly_tone_mixer: N_KEYS square-wave channels mixed with saturation.
//   clk           system clock
//   resetn        asynchronous active-low reset
//   key_in        raw key levels (asynchronous), 1 = pressed
//   octave_sel    octave shift, applied by each channel at its next reload
//   sample_req    one-cycle request for a sample
//   sample_out    signed mixed sample, updated the cycle after a request
//   sample_valid  one-cycle pulse marking a new sample_out
//   active_count  registered count of pressed (synchronised) keys
// Optional feature macro: VOLUME_ENVELOPE_EN (release decay envelope,
// stepped every DECAY_DIV cycles by a shared prescaler).
module poly_tone_mixer
  import piano_pkg::*;
#(
  parameter int        N_KEYS    = 8,
  parameter int        SAMPLE_W  = 16,
  parameter int        AMP       = 4096,
  parameter int        PERIOD_W  = 20,
`ifdef VOLUME_ENVELOPE_EN
  parameter int        DECAY_DIV = 4096,
`endif
  parameter half_tab_t HALF_TAB  = HALF_PERIOD
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_KEYS-1:0]          key_in,
  input  logic [1:0]                 octave_sel,
  input  logic                       sample_req,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic [4:0]                 active_count
);

  localparam int SUM_W = SAMPLE_W + $clog2(N_KEYS);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (SAMPLE_W - 1)));

  function automatic logic signed [SAMPLE_W-1:0] sat_f(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX) begin
      sat_f = SAT_MAX[SAMPLE_W-1:0];
    end else if (v < SAT_MIN) begin
      sat_f = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_f = v[SAMPLE_W-1:0];
    end
  endfunction

  logic [N_KEYS-1:0]          sync1_q, key_s_q;
  logic [4:0]                 active_count_q, active_count_d;
  logic signed [SAMPLE_W-1:0] contrib_s [N_KEYS];
  logic signed [SUM_W-1:0]    sum_s;
  logic signed [SAMPLE_W-1:0] mix_q, sample_out_q;
  logic                       sample_valid_q;

`ifdef VOLUME_ENVELOPE_EN
  localparam int PRESC_W = $clog2(DECAY_DIV + 1);
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               decay_tick_s;

  // Shared envelope prescaler: one tick every DECAY_DIV cycles.
  always_comb begin
    decay_tick_s = (presc_q == PRESC_W'(DECAY_DIV - 1));
    if (decay_tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    tone_channel #(
      .SAMPLE_W (SAMPLE_W),
      .AMP      (AMP),
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk_i        (clk),
      .rst_ni       (resetn),
      .key_i        (key_s_q[i]),
`ifdef VOLUME_ENVELOPE_EN
      .decay_tick_i (decay_tick_s),
`endif
      .half_base_i  (PERIOD_W'(HALF_TAB[i])),
      .octave_i     (octave_sel),
      .contrib_o    (contrib_s[i])
    );
  end

  // Popcount of the synchronised keys and signed sum of all contributions.
  always_comb begin
    active_count_d = '0;
    sum_s          = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      active_count_d = active_count_d + 5'(key_s_q[i]);
      sum_s          = sum_s + SUM_W'(contrib_s[i]);
    end
  end

  // Two-flop key synchroniser, count, mix register and sample handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q        <= '0;
      key_s_q        <= '0;
      active_count_q <= '0;
      mix_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sync1_q        <= key_in;
      key_s_q        <= sync1_q;
      active_count_q <= active_count_d;
      mix_q          <= sat_f(sum_s);
      if (sample_req) begin
        sample_out_q <= mix_q;
      end else begin
        sample_out_q <= sample_out_q;
      end
      sample_valid_q <= sample_req;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign active_count = active_count_q;

endmodule
